// File: rtl/mops_config_sequencer.sv
// MoPS configuration sequencer: 40 MHz phase strobe, shadow/active
// parameter set with phase-safe commit, settle gating, trigger counting.
module mops_config_sequencer #(
  parameter int ADC_WIDTH    = 12,
  parameter int INT_BITS     = 19,
  parameter int OCC_BITS     = 5,
  parameter int OFS_BITS     = 4,
  parameter int SETTLE_TICKS = 120,
  parameter int CNT_BITS     = 24
) (
  input  logic                 CLK120,
  input  logic                 RESET,
  input  logic                 WR_EN,
  input  logic [3:0]           WR_ADDR,
  input  logic [31:0]          WR_DATA,
  input  logic                 COMMIT,
  output logic                 BUSY,
  output logic [1:0]           ENABLE40,
  output logic [ADC_WIDTH-1:0] MIN0,
  output logic [ADC_WIDTH-1:0] MIN1,
  output logic [ADC_WIDTH-1:0] MIN2,
  output logic [ADC_WIDTH-1:0] MAX0,
  output logic [ADC_WIDTH-1:0] MAX1,
  output logic [ADC_WIDTH-1:0] MAX2,
  output logic [2:0]           TRIG_ENABLE,
  output logic [OCC_BITS-1:0]  OCCUPANCY,
  output logic [INT_BITS-1:0]  INT,
  output logic [OFS_BITS-1:0]  OFS,
  output logic [1:0]           MULTIPLICITY,
  input  logic                 TRIG_IN,
  output logic                 TRIG_OUT,
  input  logic                 COUNT_CLEAR,
  output logic [CNT_BITS-1:0]  TRIG_COUNT
);

  localparam int SW = $clog2(SETTLE_TICKS + 2);

  typedef enum logic [1:0] {
    S_RUN,
    S_PEND,
    S_SETTLE
  } state_t;

  state_t state, state_n;

  logic [SW-1:0] settle_cnt;
  logic          run;
  logic          xfer;
  logic          trig_d;
  logic [1:0]    mult_act;

  logic [ADC_WIDTH-1:0] sh_min0, sh_min1, sh_min2;
  logic [ADC_WIDTH-1:0] sh_max0, sh_max1, sh_max2;
  logic [2:0]           sh_ten;
  logic [OCC_BITS-1:0]  sh_occ;
  logic [INT_BITS-1:0]  sh_int;
  logic [OFS_BITS-1:0]  sh_ofs;
  logic [1:0]           sh_mult;

  logic [ADC_WIDTH-1:0] nx_min0, nx_min1, nx_min2;
  logic [ADC_WIDTH-1:0] nx_max0, nx_max1, nx_max2;
  logic [2:0]           nx_ten;
  logic [OCC_BITS-1:0]  nx_occ;
  logic [INT_BITS-1:0]  nx_int;
  logic [OFS_BITS-1:0]  nx_ofs;
  logic [1:0]           nx_mult;

  logic unused_wr;
  assign unused_wr = ^WR_DATA;

  assign run  = (state == S_RUN);
  assign xfer = (state == S_PEND) && (ENABLE40 == 2'd2);

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      ENABLE40 <= 2'd0;
    end else if (ENABLE40 == 2'd2) begin
      ENABLE40 <= 2'd0;
    end else begin
      ENABLE40 <= ENABLE40 + 2'd1;
    end
  end

  // Next shadow value; the transfer loads from this so a write
  // coincident with the transfer cycle is included.
  always_comb begin
    nx_min0 = sh_min0;
    nx_min1 = sh_min1;
    nx_min2 = sh_min2;
    nx_max0 = sh_max0;
    nx_max1 = sh_max1;
    nx_max2 = sh_max2;
    nx_ten  = sh_ten;
    nx_occ  = sh_occ;
    nx_int  = sh_int;
    nx_ofs  = sh_ofs;
    nx_mult = sh_mult;
    if (WR_EN) begin
      unique case (1'b1)
        WR_ADDR == 4'd0:  nx_min0 = WR_DATA[ADC_WIDTH-1:0];
        WR_ADDR == 4'd1:  nx_min1 = WR_DATA[ADC_WIDTH-1:0];
        WR_ADDR == 4'd2:  nx_min2 = WR_DATA[ADC_WIDTH-1:0];
        WR_ADDR == 4'd3:  nx_max0 = WR_DATA[ADC_WIDTH-1:0];
        WR_ADDR == 4'd4:  nx_max1 = WR_DATA[ADC_WIDTH-1:0];
        WR_ADDR == 4'd5:  nx_max2 = WR_DATA[ADC_WIDTH-1:0];
        WR_ADDR == 4'd6:  nx_ten  = WR_DATA[2:0];
        WR_ADDR == 4'd7:  nx_occ  = WR_DATA[OCC_BITS-1:0];
        WR_ADDR == 4'd8:  nx_int  = WR_DATA[INT_BITS-1:0];
        WR_ADDR == 4'd9:  nx_ofs  = WR_DATA[OFS_BITS-1:0];
        WR_ADDR == 4'd10: nx_mult = WR_DATA[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      sh_min0 <= '0;
      sh_min1 <= '0;
      sh_min2 <= '0;
      sh_max0 <= '1;
      sh_max1 <= '1;
      sh_max2 <= '1;
      sh_ten  <= '0;
      sh_occ  <= '0;
      sh_int  <= '0;
      sh_ofs  <= '0;
      sh_mult <= '0;
    end else begin
      sh_min0 <= nx_min0;
      sh_min1 <= nx_min1;
      sh_min2 <= nx_min2;
      sh_max0 <= nx_max0;
      sh_max1 <= nx_max1;
      sh_max2 <= nx_max2;
      sh_ten  <= nx_ten;
      sh_occ  <= nx_occ;
      sh_int  <= nx_int;
      sh_ofs  <= nx_ofs;
      sh_mult <= nx_mult;
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      MIN0        <= '0;
      MIN1        <= '0;
      MIN2        <= '0;
      MAX0        <= '1;
      MAX1        <= '1;
      MAX2        <= '1;
      TRIG_ENABLE <= '0;
      OCCUPANCY   <= '0;
      INT         <= '0;
      OFS         <= '0;
      mult_act    <= '0;
    end else if (xfer) begin
      MIN0        <= nx_min0;
      MIN1        <= nx_min1;
      MIN2        <= nx_min2;
      MAX0        <= nx_max0;
      MAX1        <= nx_max1;
      MAX2        <= nx_max2;
      TRIG_ENABLE <= nx_ten;
      OCCUPANCY   <= nx_occ;
      INT         <= nx_int;
      OFS         <= nx_ofs;
      mult_act    <= nx_mult;
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      settle_cnt <= '0;
    end else if (xfer) begin
      settle_cnt <= SW'(SETTLE_TICKS);
    end else if (state == S_SETTLE && ENABLE40 == 2'd0 &&
                 settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state <= S_RUN;
    end else begin
      state <= state_n;
    end
  end

  // Leave SETTLE on the phase-2 cycle so it spans whole 40 MHz ticks.
  always_comb begin
    state_n = state;
    unique case (state)
      S_RUN: begin
        if (COMMIT) state_n = S_PEND;
      end
      S_PEND: begin
        if (ENABLE40 == 2'd2) begin
          state_n = (SETTLE_TICKS == 0) ? S_RUN : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (COMMIT) begin
          state_n = S_PEND;
        end else if (ENABLE40 == 2'd2 && settle_cnt == '0) begin
          state_n = S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  always_comb begin
    BUSY         = !run;
    MULTIPLICITY = run ? mult_act : 2'd0;
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      TRIG_OUT   <= 1'b0;
      trig_d     <= 1'b0;
      TRIG_COUNT <= '0;
    end else begin
      TRIG_OUT <= TRIG_IN & run;
      trig_d   <= TRIG_IN;
      if (COUNT_CLEAR) begin
        TRIG_COUNT <= '0;
      end else if (TRIG_IN && !trig_d && run && !(&TRIG_COUNT)) begin
        TRIG_COUNT <= TRIG_COUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mops_config_sequencer.sv
// Scoreboard bench for mops_config_sequencer: expectations are queued
// with their due cycle when stimulus is driven, checked when due.
module tb_mops_config_sequencer;

  localparam int CB = 4;

  logic        CLK120 = 1'b0;
  logic        RESET = 1'b1;
  logic        WR_EN = 1'b0;
  logic [3:0]  WR_ADDR = '0;
  logic [31:0] WR_DATA = '0;
  logic        COMMIT = 1'b0;
  logic        TRIG_IN = 1'b0;
  logic        COUNT_CLEAR = 1'b0;
  logic        BUSY;
  logic [1:0]  ENABLE40;
  logic [11:0] MIN0, MIN1, MIN2;
  logic [11:0] MAX0, MAX1, MAX2;
  logic [2:0]  TRIG_ENABLE;
  logic [4:0]  OCCUPANCY;
  logic [18:0] INT;
  logic [3:0]  OFS;
  logic [1:0]  MULTIPLICITY;
  logic        TRIG_OUT;
  logic [CB-1:0] TRIG_COUNT;

  mops_config_sequencer #(.CNT_BITS(CB)) dut (
    .CLK120(CLK120), .RESET(RESET),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .COMMIT(COMMIT), .BUSY(BUSY), .ENABLE40(ENABLE40),
    .MIN0(MIN0), .MIN1(MIN1), .MIN2(MIN2),
    .MAX0(MAX0), .MAX1(MAX1), .MAX2(MAX2),
    .TRIG_ENABLE(TRIG_ENABLE), .OCCUPANCY(OCCUPANCY),
    .INT(INT), .OFS(OFS), .MULTIPLICITY(MULTIPLICITY),
    .TRIG_IN(TRIG_IN), .TRIG_OUT(TRIG_OUT),
    .COUNT_CLEAR(COUNT_CLEAR), .TRIG_COUNT(TRIG_COUNT)
  );

  always #5 CLK120 = ~CLK120;

  typedef enum {
    O_EN, O_BUSY, O_MIN0, O_MIN1, O_MIN2, O_MAX0, O_MAX1,
    O_TEN, O_OCC, O_INT, O_OFS, O_MULT, O_TOUT, O_CNT
  } sig_t;

  typedef struct {
    int          cyc;
    sig_t        sig;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  base = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge CLK120) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input sig_t s);
    case (s)
      O_EN:    return 32'(ENABLE40);
      O_BUSY:  return 32'(BUSY);
      O_MIN0:  return 32'(MIN0);
      O_MIN1:  return 32'(MIN1);
      O_MIN2:  return 32'(MIN2);
      O_MAX0:  return 32'(MAX0);
      O_MAX1:  return 32'(MAX1);
      O_TEN:   return 32'(TRIG_ENABLE);
      O_OCC:   return 32'(OCCUPANCY);
      O_INT:   return 32'(INT);
      O_OFS:   return 32'(OFS);
      O_MULT:  return 32'(MULTIPLICITY);
      O_TOUT:  return 32'(TRIG_OUT);
      default: return 32'(TRIG_COUNT);
    endcase
  endfunction

  always @(negedge CLK120) begin
    sig_t s;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        s = sb[i].sig;
        chk(s.name(), obs(s), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int c, input sig_t s,
                        input logic [31:0] v);
    sb_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge CLK120);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_phase(input int p);
    while (((cyc - base) % 3) != p) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    WR_EN = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t;
    repeat (3) tick();
    base = cyc;
    RESET = 1'b0;
    for (int d = 3; d <= 11; d++) exp_at(base + d, O_EN, d % 3);
    exp_at(base + 1, O_MAX0, 'hFFF);
    exp_at(base + 1, O_MIN0, 0);
    exp_at(base + 1, O_MULT, 0);
    exp_at(base + 1, O_BUSY, 0);
    exp_at(base + 1, O_CNT, 0);
    exp_at(base + 1, O_TEN, 0);
    goto(base + 12);

    // shadow writes, then a phase-0 commit
    wr(4'd0, 'h010);
    wr(4'd3, 'h0A0);
    wr(4'd10, 2);
    wr(4'd6, 5);
    wr(4'd7, 'h35);
    wr(4'd8, 'hFFFF_FFFF);
    wr(4'd12, 'hDEAD_BEEF);
    exp_at(cyc + 1, O_MIN0, 0);
    exp_at(cyc + 1, O_MAX0, 'hFFF);
    exp_at(cyc + 1, O_MULT, 0);
    exp_at(cyc + 1, O_TEN, 0);
    tick();
    wait_phase(0);
    c = cyc;
    exp_at(c + 1, O_BUSY, 1);
    exp_at(c + 1, O_MULT, 0);
    exp_at(c + 2, O_MIN0, 0);
    exp_at(c + 2, O_MAX0, 'hFFF);
    exp_at(c + 3, O_MIN0, 'h010);
    exp_at(c + 3, O_MAX0, 'h0A0);
    exp_at(c + 3, O_MAX1, 'h123);
    exp_at(c + 3, O_TEN, 5);
    exp_at(c + 3, O_OCC, 'h15);
    exp_at(c + 3, O_INT, 'h7FFFF);
    exp_at(c + 3, O_MULT, 0);
    exp_at(c + 3, O_BUSY, 1);
    exp_at(c + 362, O_BUSY, 1);
    exp_at(c + 362, O_MULT, 0);
    exp_at(c + 363, O_BUSY, 0);
    exp_at(c + 363, O_MULT, 2);
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    tick();
    wr(4'd4, 'h123);
    goto(c + 30);
    TRIG_IN = 1'b1;
    for (int d = 1; d <= 3; d++) exp_at(c + 30 + d, O_TOUT, 0);
    exp_at(c + 34, O_CNT, 0);
    repeat (3) tick();
    TRIG_IN = 1'b0;
    goto(c + 364);

    // phase-2 commit with coincident OFS write, then re-commit in settle
    wait_phase(2);
    c = cyc;
    COMMIT = 1'b1;
    WR_EN = 1'b1;
    WR_ADDR = 4'd9;
    WR_DATA = 'hFFFF_FFF5;
    exp_at(c + 1, O_BUSY, 1);
    exp_at(c + 3, O_OFS, 0);
    exp_at(c + 4, O_OFS, 5);
    tick();
    COMMIT = 1'b0;
    WR_EN = 1'b0;
    goto(c + 151);
    COMMIT = 1'b1;
    WR_EN = 1'b1;
    WR_ADDR = 4'd1;
    WR_DATA = 'h020;
    exp_at(c + 152, O_BUSY, 1);
    exp_at(c + 152, O_MULT, 0);
    exp_at(c + 153, O_MIN1, 0);
    exp_at(c + 154, O_MIN1, 'h020);
    exp_at(c + 364, O_BUSY, 1);
    exp_at(c + 513, O_BUSY, 1);
    exp_at(c + 514, O_BUSY, 0);
    exp_at(c + 514, O_MULT, 2);
    tick();
    COMMIT = 1'b0;
    WR_EN = 1'b0;
    goto(c + 515);

    // two 3-cycle trigger pulses in RUN
    t = cyc;
    TRIG_IN = 1'b1;
    for (int d = 1; d <= 3; d++) exp_at(t + d, O_TOUT, 1);
    exp_at(t + 4, O_TOUT, 0);
    exp_at(t + 1, O_CNT, 1);
    repeat (3) tick();
    TRIG_IN = 1'b0;
    repeat (3) tick();
    TRIG_IN = 1'b1;
    for (int d = 7; d <= 9; d++) exp_at(t + d, O_TOUT, 1);
    exp_at(t + 10, O_TOUT, 0);
    exp_at(t + 7, O_CNT, 2);
    exp_at(t + 10, O_CNT, 2);
    repeat (3) tick();
    TRIG_IN = 1'b0;
    repeat (2) tick();

    // clear wins over a coincident rising edge
    t = cyc;
    TRIG_IN = 1'b1;
    COUNT_CLEAR = 1'b1;
    exp_at(t + 1, O_CNT, 0);
    exp_at(t + 1, O_TOUT, 1);
    exp_at(t + 4, O_CNT, 0);
    tick();
    COUNT_CLEAR = 1'b0;
    repeat (2) tick();
    TRIG_IN = 1'b0;
    repeat (2) tick();

    // saturation of the narrow counter
    for (int i = 1; i <= 17; i++) begin
      t = cyc;
      TRIG_IN = 1'b1;
      exp_at(t + 1, O_CNT, (i > 15) ? 15 : i);
      tick();
      TRIG_IN = 1'b0;
      tick();
    end
    COUNT_CLEAR = 1'b1;
    exp_at(cyc + 1, O_CNT, 0);
    tick();
    COUNT_CLEAR = 1'b0;
    TRIG_IN = 1'b1;
    exp_at(cyc + 1, O_CNT, 1);
    tick();
    TRIG_IN = 1'b0;
    tick();

    // reset during PEND discards the commit and shadow contents
    wr(4'd2, 'h055);
    wr(4'd6, 7);
    wait_phase(2);
    c = cyc;
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    RESET = 1'b1;
    exp_at(c + 2, O_BUSY, 0);
    exp_at(c + 2, O_EN, 0);
    exp_at(c + 3, O_EN, 1);
    exp_at(c + 4, O_EN, 2);
    exp_at(c + 5, O_EN, 0);
    exp_at(c + 2, O_MIN2, 0);
    exp_at(c + 2, O_MAX0, 'hFFF);
    exp_at(c + 2, O_MAX1, 'hFFF);
    exp_at(c + 2, O_OFS, 0);
    exp_at(c + 2, O_INT, 0);
    exp_at(c + 2, O_CNT, 0);
    exp_at(c + 6, O_MIN2, 0);
    exp_at(c + 6, O_TEN, 0);
    exp_at(c + 6, O_BUSY, 0);
    tick();
    RESET = 1'b0;
    base = c + 2;
    goto(c + 7);

    // phase-1 commit: one-cycle latency, shadow back at defaults
    wait_phase(1);
    c = cyc;
    COMMIT = 1'b1;
    WR_EN = 1'b1;
    WR_ADDR = 4'd2;
    WR_DATA = 'h066;
    exp_at(c + 1, O_BUSY, 1);
    exp_at(c + 1, O_MIN2, 0);
    exp_at(c + 2, O_MIN2, 'h066);
    exp_at(c + 2, O_TEN, 0);
    exp_at(c + 2, O_MAX0, 'hFFF);
    exp_at(c + 2, O_BUSY, 1);
    exp_at(c + 2, O_MULT, 0);
    tick();
    COMMIT = 1'b0;
    WR_EN = 1'b0;
    goto(c + 4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mops_config_sequencer.md
Name: mops_config_sequencer

Overview:
- Sequences and configures the 40 MHz MoPS trigger datapath from the 120 MHz domain.
- Generates the 3-phase ENABLE40 strobe and holds the MoPS parameter set (per-PMT MIN/MAX, TRIG_ENABLE, OCCUPANCY, INT, OFS, MULTIPLICITY).
- Processor writes go to shadow registers. An atomic commit copies them to the active outputs at a phase-safe point, then suppresses triggers for a settle period while the occupancy windows refill.
- Gates and counts the MoPS trigger output.

Parameters:
ADC_WIDTH, 12, width of MIN/MAX thresholds
INT_BITS, 19, width of INT integral threshold
OCC_BITS, 5, width of OCCUPANCY threshold
OFS_BITS, 4, width of OFS veto offset
SETTLE_TICKS, 120, number of 40 MHz ticks of trigger suppression after a commit (matches MoPS window length)
CNT_BITS, 24, width of trigger counter

Ports:
CLK120  in  1  120 MHz clock
RESET  in  1  synchronous active-high reset
WR_EN  in  1  shadow register write strobe
WR_ADDR  in  4  shadow register address
WR_DATA  in  32  write data, LSB-aligned
COMMIT  in  1  request shadow->active transfer
BUSY  out  1  high in PEND or SETTLE
ENABLE40  out  2  phase counter 0,1,2
MIN0, MIN1, MIN2  out  ADC_WIDTH  active minimum step thresholds
MAX0, MAX1, MAX2  out  ADC_WIDTH  active maximum step thresholds
TRIG_ENABLE  out  3  active per-PMT enables
OCCUPANCY  out  OCC_BITS  active occupancy threshold
INT  out  INT_BITS  active integral threshold
OFS  out  OFS_BITS  active veto offset
MULTIPLICITY  out  2  active multiplicity; forced 0 outside RUN
TRIG_IN  in  1  raw trigger from MoPS datapath
TRIG_OUT  out  1  gated trigger
COUNT_CLEAR  in  1  clear trigger counter
TRIG_COUNT  out  CNT_BITS  accepted trigger count

Behaviour:
- Reset values:
  - ENABLE40=0, state RUN, BUSY=0.
  - Shadow and active: MINx=0, MAXx=all ones, TRIG_ENABLE=0, OCCUPANCY=0, INT=0, OFS=0, MULTIPLICITY=0.
  - TRIG_OUT=0, TRIG_COUNT=0, settle counter=0.
  - RESET mid-PEND or mid-SETTLE returns to these values next cycle; a pending commit is discarded.
- ENABLE40: increments every cycle, wraps 2->0; free-running, never stalled by state.
- Address map (write-only shadow; extra WR_DATA bits ignored):
  - 0-2 MIN0-2, 3-5 MAX0-2, 6 TRIG_ENABLE, 7 OCCUPANCY, 8 INT, 9 OFS, 10 MULTIPLICITY.
  - 11-15: write ignored, no error.
- Writes: always accepted in any state; they update shadow only, one cycle after WR_EN.
- State machine:
  - RUN:
    - COMMIT=1 -> PEND.
  - PEND:
    - On the first cycle with ENABLE40==2, all active registers load from shadow on that clock edge, so new values are stable from the following phase-0 cycle.
    - The settle counter loads SETTLE_TICKS on the same edge.
    - Next state: SETTLE, or RUN if SETTLE_TICKS==0.
    - Further COMMITs while in PEND are merged (no effect).
  - SETTLE:
    - Counter decrements on each cycle with ENABLE40==0; when it reaches 0 -> RUN.
    - SETTLE lasts exactly SETTLE_TICKS phase-0 cycles.
    - COMMIT in SETTLE -> PEND; settle restarts after the new transfer.
- Commit latency: 1-3 cycles from COMMIT to transfer edge, depending on phase. COMMIT in a phase-2 cycle while in RUN transfers at the next phase-2 cycle (3 cycles later).
- Shadow writes landing on or before the transfer edge are included, including WR_EN coincident with COMMIT or with the transfer cycle.
- MULTIPLICITY output: active value in RUN, 0 in PEND/SETTLE (disables the datapath trigger).
- TRIG_OUT:
  - Registered TRIG_IN AND (state==RUN), 1-cycle latency.
  - Follows the level of TRIG_IN, so a 3-cycle datapath pulse gives a 3-cycle TRIG_OUT.
- TRIG_COUNT:
  - Increments on each rising edge of TRIG_IN seen in RUN (one count per 40 MHz pulse); saturates at all ones.
  - COUNT_CLEAR has priority: a coincident rising edge is lost and the count reads 0.

Test Plan:
- Reset, then observe 9 cycles -> ENABLE40 sequence 0,1,2,0,1,2,0,1,2; MAX0=0xFFF, MULTIPLICITY=0, BUSY=0, TRIG_COUNT=0.
- Write MIN0=0x010, MAX0=0x0A0, MULTIPLICITY=2 (no COMMIT) -> outputs unchanged. Then COMMIT in a phase-0 cycle -> outputs update on the edge ending the next phase-2 cycle. BUSY=1 for 2 + 3*120 cycles. MULTIPLICITY reads 0 until RUN, then 2.
- COMMIT asserted in a phase-2 cycle with WR_EN to addr 9 (OFS=5) in the same cycle -> transfer 3 cycles later with OFS=5.
- During SETTLE (tick 50), set MIN1=0x020 and pulse COMMIT -> MIN1 transfers at the next phase-2 cycle and SETTLE restarts for a full 120 ticks.
- In RUN, drive two 3-cycle TRIG_IN pulses -> TRIG_OUT mirrors them delayed 1 cycle and TRIG_COUNT=2. A TRIG_IN pulse during SETTLE -> TRIG_OUT=0 and count unchanged.
- COUNT_CLEAR coincident with a TRIG_IN rising edge -> TRIG_COUNT=0. Force the count to all ones and then trigger -> it stays saturated. RESET during PEND -> RUN, active values at reset defaults, no later transfer.
